// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use / MDU stall, branch flush and MDU countdown tracking
module hazard_stall_unit #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       RsAddr_1_to_2,
    input  logic [4:0]       RtAddr_1_to_2,
    input  logic             use_rs_1_to_2,
    input  logic             use_rt_1_to_2,
    input  logic             is_mdu_1_to_2,
    input  logic [4:0]       RdAddr_2_to_3,
    input  logic             Reg_w_2_to_3,
    input  logic             Mem_r_2_to_3,
    input  logic             mdu_start_2_to_3,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mdu_busy,
    output logic             mdu_wb_valid,
    output logic [4:0]       mdu_rd,
    output logic             mdu_overlap_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MDU_LATENCY - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic [4:0]       r_mdu_rd;
    logic [4:0]       w_mdu_rd_nxt;
    logic             r_wb_valid;
    logic             w_wb_valid_nxt;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cycles;

    logic             w_busy;
    logic             w_load_use;
    logic             w_mdu_haz;
    logic             w_stall;

    assign w_busy = (r_state == S_BUSY);

    // $0 is hardwired, so every address match also requires a nonzero register
    assign w_load_use = Mem_r_2_to_3 && Reg_w_2_to_3 && (RdAddr_2_to_3 != 5'd0) &&
                        ((use_rs_1_to_2 && (RsAddr_1_to_2 == RdAddr_2_to_3)) ||
                         (use_rt_1_to_2 && (RtAddr_1_to_2 == RdAddr_2_to_3)));

    assign w_mdu_haz = w_busy &&
                       ((use_rs_1_to_2 && (RsAddr_1_to_2 != 5'd0) && (RsAddr_1_to_2 == r_mdu_rd)) ||
                        (use_rt_1_to_2 && (RtAddr_1_to_2 != 5'd0) && (RtAddr_1_to_2 == r_mdu_rd)) ||
                        is_mdu_1_to_2);

    // the branch in EX is older than the ID instruction, so it overrides any stall
    assign w_stall = (w_load_use || w_mdu_haz) && !branch_taken;

    assign pc_write        = !w_stall;
    assign if_id_write     = !w_stall;
    assign if_id_flush     = branch_taken;
    assign id_ex_flush     = w_stall || branch_taken;
    assign mdu_busy        = w_busy;
    assign mdu_wb_valid    = r_wb_valid;
    assign mdu_rd          = r_mdu_rd;
    assign mdu_overlap_err = r_err;
    assign stall_cycles    = r_stall_cycles;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mdu_rd_nxt   = r_mdu_rd;
        w_wb_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mdu_start_2_to_3) begin
                    w_state_nxt  = S_BUSY;
                    w_cnt_nxt    = CNT_INIT;
                    w_mdu_rd_nxt = RdAddr_2_to_3;
                end
            end
            S_BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt    = S_IDLE;
                    w_wb_valid_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_mdu_rd       <= 5'd0;
            r_wb_valid     <= 1'b0;
            r_err          <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mdu_rd   <= w_mdu_rd_nxt;
            r_wb_valid <= w_wb_valid_nxt;
            if (mdu_start_2_to_3 && w_busy) begin
                r_err <= 1'b1;
            end
            if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit with a cycle-index reference model
module tb_hazard_stall_unit;

    localparam int LAT   = 4;
    localparam int CNT_W = 4;
    localparam int VW    = 7 + CNT_W;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       RsAddr_1_to_2;
    logic [4:0]       RtAddr_1_to_2;
    logic             use_rs_1_to_2;
    logic             use_rt_1_to_2;
    logic             is_mdu_1_to_2;
    logic [4:0]       RdAddr_2_to_3;
    logic             Reg_w_2_to_3;
    logic             Mem_r_2_to_3;
    logic             mdu_start_2_to_3;
    logic             branch_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mdu_busy;
    logic             mdu_wb_valid;
    logic [4:0]       mdu_rd;
    logic             mdu_overlap_err;
    logic [CNT_W-1:0] stall_cycles;

    hazard_stall_unit #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .RsAddr_1_to_2(RsAddr_1_to_2), .RtAddr_1_to_2(RtAddr_1_to_2),
        .use_rs_1_to_2(use_rs_1_to_2), .use_rt_1_to_2(use_rt_1_to_2),
        .is_mdu_1_to_2(is_mdu_1_to_2), .RdAddr_2_to_3(RdAddr_2_to_3),
        .Reg_w_2_to_3(Reg_w_2_to_3), .Mem_r_2_to_3(Mem_r_2_to_3),
        .mdu_start_2_to_3(mdu_start_2_to_3), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mdu_busy(mdu_busy), .mdu_wb_valid(mdu_wb_valid), .mdu_rd(mdu_rd),
        .mdu_overlap_err(mdu_overlap_err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       is_mdu;
        logic [4:0] rd;
        logic       reg_w;
        logic       mem_r;
        logic       start;
        logic       br;
    } stim_t;

    typedef struct {
        logic [VW-1:0] vec;
        logic [4:0]    rd;
        bit            chk_rd;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state: cycles are numbered, an MDU op started in cycle S
    // is busy during cycles S+1..S+LAT and writes back in cycle S+LAT+1
    int         cyc       = 0;
    int         start_cyc = -1000;
    logic [4:0] m_rd      = 5'd0;
    bit         m_err     = 1'b0;
    int         m_cnt     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush,
                mdu_busy, mdu_wb_valid, mdu_overlap_err, stall_cycles};
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic model_reset();
        start_cyc = -1000;
        m_rd      = 5'd0;
        m_err     = 1'b0;
        m_cnt     = 0;
    endtask

    task automatic apply(input stim_t s);
        RsAddr_1_to_2    = s.rs;
        RtAddr_1_to_2    = s.rt;
        use_rs_1_to_2    = s.use_rs;
        use_rt_1_to_2    = s.use_rt;
        is_mdu_1_to_2    = s.is_mdu;
        RdAddr_2_to_3    = s.rd;
        Reg_w_2_to_3     = s.reg_w;
        Mem_r_2_to_3     = s.mem_r;
        mdu_start_2_to_3 = s.start;
        branch_taken     = s.br;
    endtask

    // called 1 time unit after a rising edge; returns at the same phase of the next cycle
    task automatic step(input stim_t s);
        bit   busy, wbv, lu, mh, st;
        exp_t e;
        apply(s);
        busy = (start_cyc >= 0) && (cyc > start_cyc) && (cyc <= start_cyc + LAT);
        wbv  = (start_cyc >= 0) && (cyc == start_cyc + LAT + 1);
        lu   = s.mem_r && s.reg_w && (s.rd != 0) &&
               ((s.use_rs && s.rs == s.rd) || (s.use_rt && s.rt == s.rd));
        mh   = busy && ((s.use_rs && s.rs != 0 && s.rs == m_rd) ||
                        (s.use_rt && s.rt != 0 && s.rt == m_rd) || s.is_mdu);
        st   = (lu || mh) && !s.br;
        e.vec    = {!st, !st, s.br, st || s.br, busy, wbv, m_err, CNT_W'(m_cnt)};
        e.rd     = m_rd;
        e.chk_rd = busy || wbv || (start_cyc < 0);
        e.cyc    = cyc;
        exp_q.push_back(e);
        if (s.start) begin
            if (busy) m_err = 1'b1;
            else begin
                start_cyc = cyc;
                m_rd      = s.rd;
            end
        end
        if (st && m_cnt < MAXC) m_cnt++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // reset asserted between edges; outputs must clear without waiting for a clock
    task automatic async_reset();
        apply(idle_stim());
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(dut_vec()), 64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(0)}));
        check("async_reset_mdu_rd", 64'(mdu_rd), 64'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc += 2;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("cycle%0d_outputs", e.cyc), 64'(dut_vec()), 64'(e.vec));
            if (e.chk_rd) check($sformatf("cycle%0d_mdu_rd", e.cyc), 64'(mdu_rd), 64'(e.rd));
        end
    end

    function automatic stim_t mk(input int rs, input int rt, input bit urs, input bit urt,
                                 input bit ismdu, input int rd, input bit rw, input bit mr,
                                 input bit start, input bit br);
        stim_t s;
        s.rs = 5'(rs); s.rt = 5'(rt); s.use_rs = urs; s.use_rt = urt; s.is_mdu = ismdu;
        s.rd = 5'(rd); s.reg_w = rw; s.mem_r = mr; s.start = start; s.br = br;
        return s;
    endfunction

    initial begin
        stim_t s;
        rst_n = 1'b0;
        apply(idle_stim());
        #3;
        check("initial_reset_outputs", 64'(dut_vec()), 64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CNT_W'(0)}));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load-use on rs, then bubble cycle
        step(mk(5, 0, 1, 0, 0, 5, 1, 1, 0, 0));
        step(mk(5, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // load-use on rt, destination $0, consumer not reading rs
        step(mk(0, 7, 0, 1, 0, 7, 1, 1, 0, 0));
        step(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
        step(mk(5, 0, 0, 0, 0, 5, 1, 1, 0, 0));
        // MDU op to $8, consumer waits through all busy cycles
        step(mk(0, 0, 0, 0, 0, 8, 1, 0, 1, 0));
        for (int i = 0; i < 5; i++) step(mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        step(idle_stim());
        // unrelated consumer, then a second MDU op in ID
        step(mk(0, 0, 0, 0, 0, 8, 1, 0, 1, 0));
        step(mk(9, 10, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) step(mk(9, 10, 1, 1, 1, 0, 0, 0, 0, 0));
        // load-use coinciding with a taken branch
        step(mk(3, 0, 1, 0, 0, 3, 1, 1, 0, 1));
        // overlapping MDU start
        step(mk(0, 0, 0, 0, 0, 12, 1, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 13, 1, 0, 1, 0));
        for (int i = 0; i < 5; i++) step(mk(12, 13, 1, 1, 0, 0, 0, 0, 0, 0));
        // reset in the middle of a busy period (countdown 2)
        step(mk(0, 0, 0, 0, 0, 6, 1, 0, 1, 0));
        step(mk(6, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        async_reset();
        for (int i = 0; i < 6; i++) step(mk(6, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 59) == 0) async_reset();
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.use_rs = 1'($urandom_range(0, 1));
            s.use_rt = 1'($urandom_range(0, 1));
            s.is_mdu = ($urandom_range(0, 7) == 0);
            s.rd     = 5'($urandom_range(0, 3));
            s.reg_w  = 1'($urandom_range(0, 1));
            s.mem_r  = 1'($urandom_range(0, 1));
            s.start  = ($urandom_range(0, 5) == 0);
            s.br     = ($urandom_range(0, 5) == 0);
            step(s);
        end
        apply(idle_stim());
        @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline: the stall-side counterpart of operand forwarding.
- Forwarding resolves RAW hazards by bypass. This block detects hazards that bypass cannot cover:
  - load-use hazards;
  - results pending from the multi-cycle multiply/divide unit (MDU).
- For these it freezes PC and IF/ID, and injects bubbles into ID/EX.
- It also converts a taken branch resolved in EX into IF/ID and ID/EX flushes, and tracks the in-flight MDU destination with a countdown state machine.

Parameters:
- MDU_LATENCY, 4, EX-to-result cycles of the MDU (legal range 2..15).
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- RsAddr_1_to_2  input  5  rs field of instruction in ID
- RtAddr_1_to_2  input  5  rt field of instruction in ID
- use_rs_1_to_2  input  1  ID instruction reads rs
- use_rt_1_to_2  input  1  ID instruction reads rt
- is_mdu_1_to_2  input  1  ID instruction is an MDU op
- RdAddr_2_to_3  input  5  destination of instruction in EX
- Reg_w_2_to_3  input  1  EX instruction writes a register
- Mem_r_2_to_3  input  1  EX instruction is a load
- mdu_start_2_to_3  input  1  EX instruction launches an MDU op
- branch_taken  input  1  branch/jump in EX resolved taken
- pc_write  output  1  1 = PC may update
- if_id_write  output  1  1 = IF/ID may load
- if_id_flush  output  1  clear IF/ID to NOP
- id_ex_flush  output  1  load NOP into ID/EX
- mdu_busy  output  1  MDU result outstanding
- mdu_wb_valid  output  1  one-cycle pulse: MDU result written this cycle
- mdu_rd  output  5  destination of outstanding MDU op
- mdu_overlap_err  output  1  sticky: mdu_start seen while busy
- stall_cycles  output  CNT_W  count of stall cycles

Behaviour:
- Reset (rst_n=0, async) forces:
  - state IDLE, countdown=0;
  - mdu_rd=0, mdu_wb_valid=0, mdu_overlap_err=0, stall_cycles=0.
  - Combinational outputs then evaluate to pc_write=1, if_id_write=1, flushes=0 given idle inputs.
- Register $0 never creates a hazard. All address matches require a nonzero address.
- load_use (combinational), true when:
  - Mem_r_2_to_3 & Reg_w_2_to_3 & RdAddr_2_to_3!=0, and
  - either (use_rs & RsAddr==RdAddr_2_to_3) or (use_rt & RtAddr==RdAddr_2_to_3).
- mdu_haz (combinational), true when:
  - state BUSY, and
  - either (use_rs & RsAddr==mdu_rd) or (use_rt & RtAddr==mdu_rd) or is_mdu_1_to_2.
- stall = (load_use | mdu_haz) & ~branch_taken.
- Output equations:
  - pc_write = ~stall
  - if_id_write = ~stall
  - if_id_flush = branch_taken
  - id_ex_flush = stall | branch_taken
- Branch priority: a taken branch in EX is older than the ID instruction. It wins over any stall: PC loads the target and both IF/ID and ID/EX are flushed.
- Load-use stall lasts exactly 1 cycle. After one bubble, the load sits in MEM and forwarding covers it.
- FSM, states IDLE and BUSY:
  - IDLE: mdu_start_2_to_3=1 moves to BUSY next edge. It also sets countdown=MDU_LATENCY-1 and mdu_rd=RdAddr_2_to_3. Acceptance is independent of branch_taken, since the EX instruction is older.
  - BUSY with countdown>0: countdown decrements.
  - BUSY with countdown==0: next edge moves to IDLE and asserts mdu_wb_valid for exactly that following cycle. mdu_rd holds its value through that cycle.
  - mdu_busy = (state==BUSY).
  - The ID consumer stalls through every BUSY cycle, including countdown==0. It is released in the mdu_wb_valid cycle, where the result is forwarded from WB.
- mdu_start_2_to_3 while BUSY is illegal and is ignored: no restart, counter unaffected. It sets mdu_overlap_err until reset.
- stall_cycles increments on each edge with stall=1 and saturates at all-ones (no wrap). Branch flushes are not counted.
- Load_use and mdu_haz together produce a single stall; the counter increments once.

Test Plan:
- lw $5 in EX (Mem_r=1, Reg_w=1, Rd=5); ID add reads rs=5 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1, stall_cycles=1. Next cycle (EX holds bubble): pc_write=1.
- Same as previous but Rd=0, or ID use_rs=0 -> no stall, id_ex_flush=0.
- mdu_start with Rd=8 and MDU_LATENCY=4; ID reads $8 the next cycle:
  - mdu_busy=1 for 4 cycles, stall held all 4 cycles;
  - mdu_wb_valid pulses in cycle 5 with mdu_rd=8, stall released that cycle;
  - stall_cycles=4.
- BUSY with an unrelated ID instruction (rs=9, rt=10, not MDU) -> no stall. A second MDU op in ID -> stall until BUSY ends.
- load_use active and branch_taken=1 in the same cycle -> pc_write=1, if_id_flush=1, id_ex_flush=1, stall_cycles unchanged. Separately, mdu_start while BUSY -> mdu_overlap_err=1 and countdown unchanged.
- Assert rst_n=0 mid-BUSY (countdown=2) asynchronously -> immediately mdu_busy=0, mdu_rd=0, stall_cycles=0, err=0, pc_write=1. After release, no mdu_wb_valid pulse.
